mem_access_ctrl: RTL

- Sits between the EX/MEM pipeline register and DataMemory.
- Accepts one load/store request at a time and issues word-aligned accesses to DataMemory.
- Holds the array access for a parameterised number of wait cycles and performs read-modify-write for byte stores.
- Freezes the pipeline until the access completes, then returns the load data or an error.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/byte_lane_unit.sv | 29 ++
 rtl/mem_access_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int LANE_W = 2;
  localparam int BYTE_W = 8;

  // Only word accesses must be aligned; byte accesses may use any lane.
  function automatic logic is_misaligned(input logic byte_acc,
                                         input logic [LANE_W-1:0] low_bits);
    return !byte_acc && (low_bits != '0);
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane helper: extracts and extends a load lane, and
// merges a store byte into a word for read-modify-write.
module byte_lane_unit
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [LANE_W-1:0] lane,
  input  logic [BYTE_W-1:0] store_byte,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] load_ext,
  output logic [DATA_W-1:0] merged
);

  logic [BYTE_W-1:0] sel_byte;

  always_comb begin
    sel_byte = word[lane*BYTE_W +: BYTE_W];
    load_ext = {{(DATA_W-BYTE_W){sign_ext & sel_byte[BYTE_W-1]}}, sel_byte};
  end

  // Only the addressed lane changes; the rest of the fetched word is kept.
  always_comb begin
    merged = word;
    merged[lane*BYTE_W +: BYTE_W] = store_byte;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between EX/MEM and DataMemory with wait states and
// byte read-modify-write. Optional macro MEM_ACCESS_SIGN_EXT_EN adds LDRSB.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              freeze,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_w_en,
  output logic              mem_r_en,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ACCESS_SIGN_EXT_EN
  ,
  input  logic              req_signed
`endif
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              wr_q;
  logic              byte_q;
  logic              err_q;
  logic              signed_q;

  logic [DATA_W-1:0] lane_ext;
  logic [DATA_W-1:0] lane_merged;

  // Single FSM: latches the request at accept, runs the wait counter in RD
  // and captures the memory word on the last read cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      byte_q   <= 1'b0;
      err_q    <= 1'b0;
      signed_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wr_q     <= req_wr;
            byte_q   <= req_byte;
            rdata_q  <= '0;
            wait_cnt <= '0;
`ifdef MEM_ACCESS_SIGN_EXT_EN
            signed_q <= req_signed;
`else
            signed_q <= 1'b0;
`endif
            if (is_misaligned(req_byte, req_addr[LANE_W-1:0])) begin
              err_q <= 1'b1;
              state <= RESP;
            end else if (req_wr && !req_byte) begin
              err_q <= 1'b0;
              state <= WR;
            end else begin
              err_q <= 1'b0;
              state <= RD;
            end
          end
        end
        RD: begin
          if (wait_cnt == LAST_CNT) begin
            rdata_q  <= mem_rdata;
            wait_cnt <= '0;
            state    <= wr_q ? WR : RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WR:      state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  byte_lane_unit #(
    .DATA_W(DATA_W)
  ) u_lanes (
    .word      (rdata_q),
    .lane      (addr_q[LANE_W-1:0]),
    .store_byte(wdata_q[BYTE_W-1:0]),
    .sign_ext  (signed_q),
    .load_ext  (lane_ext),
    .merged    (lane_merged)
  );

  // Enables are gated by rst so a reset landing on a WR cycle writes nothing.
  always_comb begin
    req_ready  = (state == IDLE);
    freeze     = (req_valid && (state == IDLE)) || (state == RD) || (state == WR);
    mem_addr   = {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    mem_r_en   = (state == RD) && !rst;
    mem_w_en   = (state == WR) && !rst;
    mem_wdata  = '0;
    if (state == WR) begin
      mem_wdata = byte_q ? lane_merged : wdata_q;
    end
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
    resp_rdata = '0;
    if ((state == RESP) && !wr_q && !err_q) begin
      resp_rdata = byte_q ? lane_ext : rdata_q;
    end
  end

endmodule
